// File: rtl/fft_io_sched_if.sv
// Stream and core-pin bundle for fft_io_sched; master is the sequencer side,
// slave is the system/core side.
interface fft_io_sched_if #(
    parameter int ADDR_W = 9
);
    logic              iS_VALID;
    logic [15:0]       iS_DATA;
    logic              oS_READY;
    logic [15:0]       oDATA;
    logic [ADDR_W-1:0] oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
    logic              oWE_0, oWE_1, oWE_2, oWE_3;
    logic [ADDR_W-1:0] oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3;
    logic [16:0]       iRE_0, iRE_1, iRE_2, iRE_3;
    logic              oFFT_START;
    logic              iFFT_RDY;
    logic              oM_VALID;
    logic [16:0]       oM_DATA;
    logic              oM_LAST;
    logic              iM_READY;
    logic              oBUSY;
    logic              oERR;

    modport master (
        input  iS_VALID, iS_DATA, iRE_0, iRE_1, iRE_2, iRE_3, iFFT_RDY, iM_READY,
        output oS_READY, oDATA, oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
               oWE_0, oWE_1, oWE_2, oWE_3, oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
               oFFT_START, oM_VALID, oM_DATA, oM_LAST, oBUSY, oERR
    );

    modport slave (
        output iS_VALID, iS_DATA, iRE_0, iRE_1, iRE_2, iRE_3, iFFT_RDY, iM_READY,
        input  oS_READY, oDATA, oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
               oWE_0, oWE_1, oWE_2, oWE_3, oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
               oFFT_START, oM_VALID, oM_DATA, oM_LAST, oBUSY, oERR
    );
endinterface

// File: rtl/fft_io_sched.sv
// Frame sequencer around the FFT core RAM_A port: load -> start -> run -> unload.
// Optional RUN watchdog (oERR) is built only when FFT_IO_TIMEOUT_EN is defined.
module fft_io_sched #(
    parameter int N_POINTS = 2048,
    parameter int ADDR_W   = 9,
    parameter int RD_LAT   = 2,
    parameter int TIMEOUT  = 65535
) (
    input logic            iCLK,
    input logic            iRESET,
    fft_io_sched_if.master io
);
    localparam int CW = ADDR_W + 2;
    localparam logic [CW-1:0] LAST_IDX = CW'(N_POINTS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, UNLOAD} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]     n_cnt, k_cnt;
    logic              load_done, rd_done;
    logic              s_ready, s_hs;
    logic [15:0]       data_q;
    logic [ADDR_W-1:0] addr_wr_q;
    logic [3:0]        we_q;
    logic              rdy_q, rdy_rise;
    logic              tmo_hit;

    logic [RD_LAT:1]      vld_pipe, last_pipe;
    logic [RD_LAT:1][1:0] bank_pipe;
    logic [2:0]           inflight;
    logic [3:0]           credit_use;
    logic                 issue;

    logic [16:0] re_bus    [4];
    logic [16:0] fifo_data [4];
    logic [3:0]  fifo_last;
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  occ;
    logic        push, pop, head_last;

    assign s_ready  = (state == LOAD) && !load_done;
    assign s_hs     = s_ready && io.iS_VALID;
    assign rdy_rise = io.iFFT_RDY && !rdy_q;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (io.iS_VALID) state_nxt = LOAD;
            LOAD:    if (load_done) state_nxt = START;
            START:   state_nxt = RUN;
            RUN: begin
                if (rdy_rise)     state_nxt = UNLOAD;
                else if (tmo_hit) state_nxt = IDLE;
            end
            UNLOAD:  if (pop && head_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        io.oS_READY   = s_ready;
        io.oFFT_START = (state == START);
        io.oBUSY      = (state != IDLE);
        io.oADDR_RD_0 = '0;
        io.oADDR_RD_1 = '0;
        io.oADDR_RD_2 = '0;
        io.oADDR_RD_3 = '0;
        if (state == UNLOAD) begin
            io.oADDR_RD_0 = k_cnt[CW-1:2];
            io.oADDR_RD_1 = k_cnt[CW-1:2];
            io.oADDR_RD_2 = k_cnt[CW-1:2];
            io.oADDR_RD_3 = k_cnt[CW-1:2];
        end
    end

    // Registered write port; n saturates at the last index and load_done closes the intake.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            n_cnt     <= '0;
            load_done <= 1'b0;
            data_q    <= '0;
            addr_wr_q <= '0;
            we_q      <= '0;
        end else begin
            we_q      <= '0;
            addr_wr_q <= '0;
            if (state == IDLE) begin
                n_cnt     <= '0;
                load_done <= 1'b0;
            end else if (s_hs) begin
                data_q    <= io.iS_DATA;
                addr_wr_q <= n_cnt[CW-1:2];
                we_q      <= 4'b0001 << n_cnt[1:0];
                if (n_cnt == LAST_IDX) load_done <= 1'b1;
                else                   n_cnt     <= n_cnt + 1'b1;
            end
        end
    end

    assign io.oDATA      = data_q;
    assign io.oADDR_WR_0 = addr_wr_q;
    assign io.oADDR_WR_1 = addr_wr_q;
    assign io.oADDR_WR_2 = addr_wr_q;
    assign io.oADDR_WR_3 = addr_wr_q;
    assign io.oWE_0      = we_q[0];
    assign io.oWE_1      = we_q[1];
    assign io.oWE_2      = we_q[2];
    assign io.oWE_3      = we_q[3];

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) rdy_q <= 1'b0;
        else         rdy_q <= io.iFFT_RDY;
    end

    always_comb begin
        inflight = '0;
        for (int i = 1; i <= RD_LAT; i++) inflight = inflight + {2'b00, vld_pipe[i]};
    end

    // Buffered + in-flight never exceeds FIFO depth, so backpressure cannot overflow it.
    assign credit_use = {1'b0, occ} + {1'b0, inflight};
    assign issue      = (state == UNLOAD) && !rd_done && (credit_use < 4'd4);

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            bank_pipe <= '0;
            k_cnt     <= '0;
            rd_done   <= 1'b0;
        end else begin
            vld_pipe[1]  <= issue;
            last_pipe[1] <= issue && (k_cnt == LAST_IDX);
            bank_pipe[1] <= k_cnt[1:0];
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
                bank_pipe[i] <= bank_pipe[i-1];
            end
            if (state == IDLE) begin
                k_cnt   <= '0;
                rd_done <= 1'b0;
            end else if (issue) begin
                if (k_cnt == LAST_IDX) rd_done <= 1'b1;
                else                   k_cnt   <= k_cnt + 1'b1;
            end
        end
    end

    assign re_bus[0] = io.iRE_0;
    assign re_bus[1] = io.iRE_1;
    assign re_bus[2] = io.iRE_2;
    assign re_bus[3] = io.iRE_3;

    assign push      = vld_pipe[RD_LAT];
    assign pop       = (occ != 3'd0) && io.iM_READY;
    assign head_last = fifo_last[rd_ptr];

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            for (int i = 0; i < 4; i++) fifo_data[i] <= '0;
            fifo_last <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= re_bus[bank_pipe[RD_LAT]];
                fifo_last[wr_ptr] <= last_pipe[RD_LAT];
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: ;
            endcase
        end
    end

    assign io.oM_VALID = (occ != 3'd0);
    assign io.oM_DATA  = io.oM_VALID ? fifo_data[rd_ptr] : '0;
    assign io.oM_LAST  = io.oM_VALID && head_last;

`ifdef FFT_IO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET)           tmo_cnt <= '0;
        else if (state == RUN) tmo_cnt <= tmo_cnt + 1'b1;
        else                   tmo_cnt <= '0;
    end

    // tmo_cnt counts RUN cycles already spent, so IDLE lands exactly TIMEOUT cycles after entry.
    assign tmo_hit = (state == RUN) && !rdy_rise && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET)                                  err_q <= 1'b0;
        else if (tmo_hit)                             err_q <= 1'b1;
        else if (state == IDLE && state_nxt == LOAD)  err_q <= 1'b0;
    end

    assign io.oERR = err_q;
`else
    assign tmo_hit = 1'b0;
    assign io.oERR = 1'b0;
`endif

endmodule

// File: tb/tb_fft_io_sched.sv
// Scoreboard bench for fft_io_sched: behavioural RAM_A core model, queued write
// and result expectations, stall/reset/timeout scenarios.
module tb_fft_io_sched;
    localparam int N   = 2048;
    localparam int AW  = 9;
    localparam int RDL = 2;
`ifdef FFT_IO_TIMEOUT_EN
    localparam int TMO = 200;
`else
    localparam int TMO = 65535;
`endif

    logic iCLK = 1'b0;
    logic iRESET = 1'b0;
    always #5 iCLK = ~iCLK;

    fft_io_sched_if #(.ADDR_W(AW)) bus ();

    fft_io_sched #(.N_POINTS(N), .ADDR_W(AW), .RD_LAT(RDL), .TIMEOUT(TMO)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .io(bus)
    );

    typedef struct {
        logic [1:0]    b;
        logic [AW-1:0] a;
        logic [15:0]   d;
    } wr_t;

    int          errors = 0;
    int          checks = 0;
    bit          core_mode = 1'b0;
    logic [15:0] samp [N];
    wr_t         wr_q [$];
    logic [16:0] res_q [$];

    // Core model: banked RAM written via WE; reads return RDL cycles after the address.
    logic [15:0]   ram  [4][N/4];
    logic [AW-1:0] rd_a [4][RDL];
    logic [AW-1:0] a0, a1, a2, a3;

    always @(posedge iCLK) begin
        if (bus.oWE_0) ram[0][bus.oADDR_WR_0] <= bus.oDATA;
        if (bus.oWE_1) ram[1][bus.oADDR_WR_1] <= bus.oDATA;
        if (bus.oWE_2) ram[2][bus.oADDR_WR_2] <= bus.oDATA;
        if (bus.oWE_3) ram[3][bus.oADDR_WR_3] <= bus.oDATA;
        rd_a[0][0] <= bus.oADDR_RD_0;
        rd_a[1][0] <= bus.oADDR_RD_1;
        rd_a[2][0] <= bus.oADDR_RD_2;
        rd_a[3][0] <= bus.oADDR_RD_3;
        for (int j = 1; j < RDL; j++)
            for (int b = 0; b < 4; b++) rd_a[b][j] <= rd_a[b][j-1];
    end

    assign a0 = rd_a[0][RDL-1];
    assign a1 = rd_a[1][RDL-1];
    assign a2 = rd_a[2][RDL-1];
    assign a3 = rd_a[3][RDL-1];
    assign bus.iRE_0 = core_mode ? {ram[0][a0][15], ram[0][a0]} : 17'(int'(a0));
    assign bus.iRE_1 = core_mode ? {ram[1][a1][15], ram[1][a1]} : 17'(1000 + int'(a1));
    assign bus.iRE_2 = core_mode ? {ram[2][a2][15], ram[2][a2]} : 17'(2000 + int'(a2));
    assign bus.iRE_3 = core_mode ? {ram[3][a3][15], ram[3][a3]} : 17'(3000 + int'(a3));

    // Drives one frame's samples, checking every write cycle; returns at the START pulse
    // or once stop_at handshakes have been written.
    task automatic load_frame(input bit rnd_valid, input int stop_at);
        int n = 0, cyc = 0, last_we = -100, we_cnt = 0;
        bit done = 1'b0;
        logic [3:0] we;
        wr_t e;
        while (!done && cyc < 20000) begin
            @(negedge iCLK);
            cyc++;
            we = {bus.oWE_3, bus.oWE_2, bus.oWE_1, bus.oWE_0};
            checks++;
            if (wr_q.size() != 0) begin
                e = wr_q.pop_front();
                if (we !== (4'b0001 << e.b) || bus.oDATA !== e.d || bus.oADDR_WR_0 !== e.a ||
                    bus.oADDR_WR_1 !== e.a || bus.oADDR_WR_2 !== e.a || bus.oADDR_WR_3 !== e.a) begin
                    errors++;
                    $display("FAIL write #%0d: we=%b addr=%0d data=%0d, expected we=%b addr=%0d data=%0d",
                             we_cnt, we, bus.oADDR_WR_0, bus.oDATA, 4'b0001 << e.b, e.a, e.d);
                end
                last_we = cyc;
                we_cnt++;
            end else if (we !== 4'b0000) begin
                errors++;
                $display("FAIL stray_write: we=%b at cycle %0d, expected 0000", we, cyc);
            end
            if (bus.oFFT_START) begin
                checks++;
                if (cyc != last_we + 1 || we_cnt != N || stop_at >= 0) begin
                    errors++;
                    $display("FAIL start_timing: start at %0d after write %0d, writes=%0d, expected %0d",
                             cyc, last_we, we_cnt, N);
                end
                done = 1'b1;
            end else if (stop_at >= 0 && n >= stop_at) begin
                done = 1'b1;
            end else begin
                bus.iS_VALID = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.iS_DATA  = samp[n < N ? n : 0];
                if (n >= N) begin
                    checks++;
                    if (bus.oS_READY !== 1'b0) begin
                        errors++;
                        $display("FAIL extra_accept: oS_READY=%b after %0d samples, expected 0",
                                 bus.oS_READY, n);
                    end
                end else if (bus.iS_VALID && bus.oS_READY) begin
                    wr_q.push_back('{b: 2'(n % 4), a: AW'(n / 4), d: samp[n]});
                    res_q.push_back(core_mode ? {samp[n][15], samp[n]} : 17'((n % 4) * 1000 + n / 4));
                    n++;
                end
            end
        end
        bus.iS_VALID = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL load_timeout: %0d samples accepted, start not seen", n);
        end else if (stop_at < 0) begin
            @(negedge iCLK);
            checks++;
            if (bus.oFFT_START !== 1'b0 || bus.oBUSY !== 1'b1) begin
                errors++;
                $display("FAIL start_pulse: start=%b busy=%b one cycle later, expected 0/1",
                         bus.oFFT_START, bus.oBUSY);
            end
        end
    endtask

    task automatic fire_rdy(input int delay);
        repeat (delay) @(negedge iCLK);
        checks++;
        if (bus.oBUSY !== 1'b1 || bus.oM_VALID !== 1'b0) begin
            errors++;
            $display("FAIL run_wait: busy=%b m_valid=%b, expected 1/0", bus.oBUSY, bus.oM_VALID);
        end
        bus.iFFT_RDY = 1'b1;
    endtask

    // Pops results against the scoreboard; called right after iFFT_RDY is raised.
    task automatic unload_frame(input int stall_at, input bit rnd_ready, input bit chk_lat);
        int k = 0, cyc = 0, stall_left = 50, first = -1;
        bit prev_stall = 1'b0, prev_l = 1'b0;
        logic [16:0] prev_d = '0, exp_r;
        while (k < N && cyc < 20000) begin
            @(negedge iCLK);
            cyc++;
            if (prev_stall) begin
                checks++;
                if (bus.oM_VALID !== 1'b1 || bus.oM_DATA !== prev_d || bus.oM_LAST !== prev_l) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%0d last=%b, expected 1/%0d/%b",
                             bus.oM_VALID, bus.oM_DATA, bus.oM_LAST, prev_d, prev_l);
                end
            end
            if (stall_at >= 0 && k >= stall_at && stall_left > 0) begin
                bus.iM_READY = 1'b0;
                stall_left--;
            end else begin
                bus.iM_READY = (rnd_ready && stall_left == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (bus.oM_VALID && first < 0) first = cyc;
            if (bus.oM_VALID && bus.iM_READY) begin
                checks++;
                if (res_q.size() == 0) begin
                    errors++;
                    $display("FAIL result_extra: got %0d at k=%0d, expected nothing", bus.oM_DATA, k);
                end else begin
                    exp_r = res_q.pop_front();
                    if (bus.oM_DATA !== exp_r || bus.oM_LAST !== (k == N - 1)) begin
                        errors++;
                        $display("FAIL result k=%0d: data=%0d last=%b, expected %0d/%b",
                                 k, bus.oM_DATA, bus.oM_LAST, exp_r, k == N - 1);
                    end
                end
                k++;
            end
            prev_stall = bus.oM_VALID && !bus.iM_READY;
            prev_d     = bus.oM_DATA;
            prev_l     = bus.oM_LAST;
        end
        if (chk_lat) begin
            checks++;
            if (first != RDL + 2 || cyc != RDL + 1 + N) begin
                errors++;
                $display("FAIL unload_rate: first valid at %0d, last pop at %0d, expected %0d/%0d",
                         first, cyc, RDL + 2, RDL + 1 + N);
            end
        end
        @(negedge iCLK);
        bus.iM_READY = 1'b1;
        checks++;
        if (k != N || bus.oBUSY !== 1'b0 || bus.oM_VALID !== 1'b0 || bus.oERR !== 1'b0 ||
            res_q.size() != 0) begin
            errors++;
            $display("FAIL unload_end: results=%0d busy=%b valid=%b err=%b left=%0d, expected %0d/0/0/0/0",
                     k, bus.oBUSY, bus.oM_VALID, bus.oERR, res_q.size(), N);
        end
        bus.iFFT_RDY = 1'b0;
        repeat (3) @(negedge iCLK);
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({bus.oS_READY, bus.oDATA, bus.oADDR_WR_0, bus.oADDR_WR_1, bus.oADDR_WR_2, bus.oADDR_WR_3,
             bus.oWE_0, bus.oWE_1, bus.oWE_2, bus.oWE_3, bus.oADDR_RD_0, bus.oADDR_RD_1,
             bus.oADDR_RD_2, bus.oADDR_RD_3, bus.oFFT_START, bus.oM_VALID, bus.oM_DATA,
             bus.oM_LAST, bus.oBUSY, bus.oERR} !== '0) begin
            errors++;
            $display("FAIL %s: outputs not all zero (busy=%b we=%b%b%b%b data=%0d), expected 0",
                     tag, bus.oBUSY, bus.oWE_3, bus.oWE_2, bus.oWE_1, bus.oWE_0, bus.oDATA);
        end
    endtask

    task automatic test_reset();
        iRESET = 1'b0;
        bus.iS_VALID = 1'b1;
        repeat (3) begin
            @(negedge iCLK);
            check_all_zero("reset_outputs");
        end
        bus.iS_VALID = 1'b0;
        iRESET = 1'b1;
        @(negedge iCLK);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_ramp_load();
        core_mode = 1'b0;
        for (int i = 0; i < N; i++) samp[i] = 16'(i);
        load_frame(1'b0, -1);
    endtask

    task automatic test_unload_stream();
        fire_rdy(100);
        unload_frame(-1, 1'b0, 1'b1);
    endtask

    task automatic test_random_valid();
        core_mode = 1'b1;
        for (int i = 0; i < N; i++) samp[i] = 16'($urandom);
        load_frame(1'b1, -1);
    endtask

    task automatic test_stall_unload();
        fire_rdy(100);
        unload_frame(500, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        core_mode = 1'b1;
        for (int i = 0; i < N; i++) samp[i] = 16'($urandom);
        load_frame(1'b0, 700);
        iRESET = 1'b0;
        #1;
        check_all_zero("reset_async");
        repeat (3) begin
            @(negedge iCLK);
            check_all_zero("reset_mid_load");
        end
        wr_q.delete();
        res_q.delete();
        iRESET = 1'b1;
        @(negedge iCLK);
        for (int i = 0; i < N; i++) samp[i] = 16'(N - 1 - i) ^ 16'h8a5c;
        load_frame(1'b0, -1);
        fire_rdy(100);
        unload_frame(-1, 1'b1, 1'b0);
    endtask

`ifdef FFT_IO_TIMEOUT_EN
    task automatic test_timeout();
        int cnt = 0;
        core_mode = 1'b1;
        load_frame(1'b0, -1);
        while (bus.oBUSY && cnt < 1000) begin
            @(negedge iCLK);
            if (bus.oBUSY) cnt++;
        end
        checks++;
        if (cnt != TMO - 1 || bus.oERR !== 1'b1) begin
            errors++;
            $display("FAIL timeout: busy for %0d more cycles, err=%b, expected %0d/1", cnt, bus.oERR, TMO - 1);
        end
        res_q.delete();
        repeat (5) @(negedge iCLK);
        checks++;
        if (bus.oERR !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b in IDLE, expected 1", bus.oERR);
        end
        load_frame(1'b0, -1);
        checks++;
        if (bus.oERR !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b after new LOAD, expected 0", bus.oERR);
        end
        fire_rdy(100);
        unload_frame(-1, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        bus.iS_VALID = 1'b0;
        bus.iS_DATA  = '0;
        bus.iFFT_RDY = 1'b0;
        bus.iM_READY = 1'b1;
        test_reset();
        test_ramp_load();
        test_unload_stream();
        test_random_valid();
        test_stall_unload();
        test_reset_mid_load();
`ifdef FFT_IO_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
